// File: rtl/gpr_bank.sv
// General-purpose register bank: multi-port read/write storage, a busy scoreboard
// and a clear sweep that zeroes every register after reset or on request.
module gpr_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int GPRS_NUM   = 32,
    parameter int GPRS_WIDTH = $clog2(GPRS_NUM),
    parameter int RD_PORTS   = 3,
    parameter int WR_PORTS   = 2
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_clr,
    output logic                             o_ready,
    input  logic [RD_PORTS*GPRS_WIDTH-1:0]   i_rd_id,
    output logic [RD_PORTS*DATA_WIDTH-1:0]   o_rd_data,
    output logic [RD_PORTS-1:0]              o_rd_busy,
    input  logic [WR_PORTS-1:0]              i_wr_en,
    input  logic [WR_PORTS*GPRS_WIDTH-1:0]   i_wr_id,
    input  logic [WR_PORTS*DATA_WIDTH-1:0]   i_wr_data,
    input  logic                             i_iss_en,
    input  logic [GPRS_WIDTH-1:0]            i_iss_id
);

    localparam logic [GPRS_WIDTH-1:0] LastIdx  = GPRS_WIDTH'(GPRS_NUM - 1);
    localparam logic [GPRS_WIDTH-1:0] FirstIdx = GPRS_WIDTH'(1);

    typedef enum logic {StIdle, StClear} state_e;

    state_e                  state_q, state_d;
    logic [GPRS_WIDTH-1:0]   cnt_q, cnt_d;
    logic [GPRS_NUM-1:0]     busy_q, busy_d;
    logic [DATA_WIDTH-1:0]   regs_q [GPRS_NUM];

    logic [GPRS_WIDTH-1:0]   rd_id   [RD_PORTS];
    logic [GPRS_WIDTH-1:0]   wr_id   [WR_PORTS];
    logic [DATA_WIDTH-1:0]   wr_data [WR_PORTS];
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    idle;

    assign idle = (state_q == StIdle);

    // Unpack the flat index/data buses into per-port arrays.
    always_comb begin
        for (int k = 0; k < RD_PORTS; k++) begin
            rd_id[k] = i_rd_id[k*GPRS_WIDTH +: GPRS_WIDTH];
        end
        for (int p = 0; p < WR_PORTS; p++) begin
            wr_id[p]   = i_wr_id[p*GPRS_WIDTH +: GPRS_WIDTH];
            wr_data[p] = i_wr_data[p*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Sweep FSM state and counter; reset lands directly in a fresh sweep.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StClear;
            cnt_q   <= FirstIdx;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: i_clr only matters in idle, so a sweep is never restarted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (i_clr) begin
                    state_d = StClear;
                    cnt_d   = FirstIdx;
                end
            end
            StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastIdx) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StClear;
                cnt_d   = FirstIdx;
            end
        endcase
    end

    // Storage has no reset; the sweep zeroes one entry per cycle.
    // Ascending port loop makes the highest-numbered port win on a collision.
    always_ff @(posedge i_clk) begin
        if (!idle) begin
            regs_q[cnt_q] <= '0;
        end else begin
            for (int p = 0; p < WR_PORTS; p++) begin
                if (i_wr_en[p] && (wr_id[p] != '0)) begin
                    regs_q[wr_id[p]] <= wr_data[p];
                end
            end
        end
    end

    // Scoreboard next value: writes clear, then issue sets so issue wins.
    always_comb begin
        busy_d = busy_q;
        if (idle) begin
            if (i_clr) begin
                busy_d = '0;
            end else begin
                for (int p = 0; p < WR_PORTS; p++) begin
                    if (i_wr_en[p]) begin
                        busy_d[wr_id[p]] = 1'b0;
                    end
                end
                if (i_iss_en) begin
                    busy_d[i_iss_id] = 1'b1;
                end
            end
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Outputs: combinational reads with write-through bypass, blanked while sweeping.
    always_comb begin
        o_ready   = idle;
        o_rd_data = '0;
        o_rd_busy = '0;
        rd_word   = '0;
        for (int k = 0; k < RD_PORTS; k++) begin
            if (idle && (rd_id[k] != '0)) begin
                rd_word = regs_q[rd_id[k]];
                for (int p = 0; p < WR_PORTS; p++) begin
                    if (i_wr_en[p] && (wr_id[p] == rd_id[k])) begin
                        rd_word = wr_data[p];
                    end
                end
                o_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_word;
                o_rd_busy[k] = busy_q[rd_id[k]];
            end
        end
    end

endmodule

// File: tb/tb_gpr_bank.sv
// Self-checking bench for gpr_bank: directed scenarios followed by random traffic,
// all checked against a behavioural register-file model.
module tb_gpr_bank;

    localparam int N  = 32;
    localparam int DW = 32;
    localparam int GW = 5;
    localparam int RP = 3;
    localparam int WP = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr;
    logic              ready;
    logic [RP*GW-1:0]  rd_id;
    logic [RP*DW-1:0]  rd_data;
    logic [RP-1:0]     rd_busy;
    logic [WP-1:0]     wr_en;
    logic [WP*GW-1:0]  wr_id;
    logic [WP*DW-1:0]  wr_data;
    logic              iss_en;
    logic [GW-1:0]     iss_id;

    int n_asrt = 0;
    int n_fail = 0;

    // Reference model: register contents, busy flags, remaining sweep cycles.
    logic [DW-1:0] m_mem  [N];
    bit            m_busy [N];
    int            clear_left;

    gpr_bank #(
        .DATA_WIDTH (DW),
        .GPRS_NUM   (N),
        .GPRS_WIDTH (GW),
        .RD_PORTS   (RP),
        .WR_PORTS   (WP)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_clr     (clr),
        .o_ready   (ready),
        .i_rd_id   (rd_id),
        .o_rd_data (rd_data),
        .o_rd_busy (rd_busy),
        .i_wr_en   (wr_en),
        .i_wr_id   (wr_id),
        .i_wr_data (wr_data),
        .i_iss_en  (iss_en),
        .i_iss_id  (iss_id)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [DW-1:0] exp_rd(input logic [GW-1:0] id);
        logic [DW-1:0] r;
        if (clear_left > 0 || id == 0) return '0;
        r = m_mem[id];
        for (int p = 0; p < WP; p++) begin
            if (wr_en[p] && wr_id[p*GW +: GW] == id) r = wr_data[p*DW +: DW];
        end
        return r;
    endfunction

    function automatic logic exp_busy(input logic [GW-1:0] id);
        if (clear_left > 0 || id == 0) return 1'b0;
        return m_busy[id];
    endfunction

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_asrt++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [GW-1:0] id;
        check_val("ready", {31'd0, ready}, {31'd0, clear_left == 0});
        for (int k = 0; k < RP; k++) begin
            id = rd_id[k*GW +: GW];
            check_val($sformatf("rd_data[%0d] id %0d", k, id), rd_data[k*DW +: DW], exp_rd(id));
            check_val($sformatf("rd_busy[%0d] id %0d", k, id), {31'd0, rd_busy[k]},
                      {31'd0, exp_busy(id)});
        end
    endtask

    task automatic model_reset();
        clear_left = N - 1;
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 1'b0;
            m_mem[i]  = '0;
        end
    endtask

    task automatic model_edge();
        logic [GW-1:0] id;
        if (!rst_n) return;
        if (clear_left > 0) begin
            clear_left--;
        end else if (clr) begin
            model_reset();
        end else begin
            for (int p = 0; p < WP; p++) begin
                id = wr_id[p*GW +: GW];
                if (wr_en[p] && id != 0) begin
                    m_mem[id]  = wr_data[p*DW +: DW];
                    m_busy[id] = 1'b0;
                end
            end
            if (iss_en && iss_id != 0) m_busy[iss_id] = 1'b1;
        end
    endtask

    // One clock: check outputs mid-cycle, advance the model at the edge.
    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Count edges until o_ready rises; optional clr pulse at edge index pulse_at.
    task automatic wait_ready(input string tag, input int pulse_at, input bit hold_clr);
        int n = 0;
        while (!ready && n < 100) begin
            clr = hold_clr || (n == pulse_at);
            for (int k = 0; k < RP; k++) rd_id[k*GW +: GW] = GW'($urandom_range(1, N - 1));
            cycle();
            n++;
        end
        if (!hold_clr) clr = 1'b0;
        check_val(tag, n, N - 1);
    endtask

    initial begin
        rst_n = 1'b1; clr = 1'b0; rd_id = '0; wr_en = '0; wr_id = '0; wr_data = '0;
        iss_en = 1'b0; iss_id = '0;
        model_reset();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("ready in reset", {31'd0, ready}, 32'd0);
        cycle();
        cycle();
        rst_n = 1'b1;
        wait_ready("reset sweep length", -1, 1'b0);
        for (int k = 0; k < RP; k++) rd_id[k*GW +: GW] = GW'(k + 1);
        cycle();

        // Write-through bypass then storage.
        rd_id = {5'd0, 5'd0, 5'd5};
        wr_en = 2'b01; wr_id = {5'd0, 5'd5}; wr_data = {32'd0, 32'hDEADBEEF};
        #1 check_val("bypass id5", rd_data[31:0], 32'hDEADBEEF);
        cycle();
        wr_en = '0;
        #1 check_val("stored id5", rd_data[31:0], 32'hDEADBEEF);
        repeat (3) cycle();
        check_val("stored id5 later", rd_data[31:0], 32'hDEADBEEF);

        // Same-index collision: highest port wins; index 0 stays zero.
        rd_id = {5'd0, 5'd7, 5'd5};
        wr_en = 2'b11; wr_id = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
        #1 check_val("collision bypass", rd_data[63:32], 32'h22);
        cycle();
        wr_en = '0;
        #1 check_val("collision stored", rd_data[63:32], 32'h22);
        wr_en = 2'b01; wr_id = {5'd0, 5'd0}; wr_data = {32'd0, 32'hFF};
        #1 check_val("r0 bypass", rd_data[95:64], 32'd0);
        cycle();
        wr_en = '0;
        #1 check_val("r0 stored", rd_data[95:64], 32'd0);

        // Scoreboard.
        rd_id = {5'd0, 5'd0, 5'd9};
        iss_en = 1'b1; iss_id = 5'd9;
        #1 check_val("busy no bypass", {31'd0, rd_busy[0]}, 32'd0);
        cycle();
        iss_en = 1'b0;
        #1 check_val("busy after issue", {31'd0, rd_busy[0]}, 32'd1);
        wr_en = 2'b10; wr_id = {5'd9, 5'd0}; wr_data = {32'h99, 32'h0};
        cycle();
        wr_en = '0;
        #1 check_val("busy after write", {31'd0, rd_busy[0]}, 32'd0);
        iss_en = 1'b1; wr_en = 2'b01; wr_id = {5'd0, 5'd9}; wr_data = {32'h0, 32'h98};
        cycle();
        iss_en = 1'b0; wr_en = '0;
        #1 check_val("issue beats write", {31'd0, rd_busy[0]}, 32'd1);
        cycle();

        // Clear sweep with data present and a mid-sweep clr pulse.
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        wait_ready("clr sweep length", 5, 1'b0);
        for (int base = 1; base < N; base += RP) begin
            for (int k = 0; k < RP; k++) rd_id[k*GW +: GW] = GW'((base + k) % N);
            cycle();
        end
        rd_id = {5'd9, 5'd7, 5'd5};
        #1 check_val("id5 after sweep", rd_data[31:0], 32'd0);

        // clr held across the exit: one idle cycle, then a new sweep.
        clr = 1'b1;
        cycle();
        wait_ready("held clr sweep", -1, 1'b1);
        cycle();
        check_val("resweep after idle", {31'd0, ready}, 32'd0);
        clr = 1'b0;
        wait_ready("second held sweep", -1, 1'b0);

        // Reset at sweep cycle 10 restarts the full sweep.
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        repeat (10) cycle();
        rst_n = 1'b0;
        model_reset();
        cycle();
        rst_n = 1'b1;
        wait_ready("reset mid sweep", -1, 1'b0);

        // Random traffic.
        for (int t = 0; t < 500; t++) begin
            wr_en = 2'($urandom);
            for (int p = 0; p < WP; p++) begin
                wr_id[p*GW +: GW] = ($urandom_range(0, 1) == 0) ? GW'($urandom_range(0, 7))
                                                               : GW'($urandom_range(0, N - 1));
                wr_data[p*DW +: DW] = $urandom;
            end
            for (int k = 0; k < RP; k++) begin
                rd_id[k*GW +: GW] = ($urandom_range(0, 1) == 0) ? GW'($urandom_range(0, 7))
                                                               : GW'($urandom_range(0, N - 1));
            end
            iss_en = ($urandom_range(0, 3) == 0);
            iss_id = GW'($urandom_range(0, 7));
            clr    = ($urandom_range(0, 99) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/gpr_bank.md
GPR_BANK -- requirements
Module: gpr_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width in bits.
REQ-002 SHALL have parameter GPRS_NUM, default 32, register count (power of two, at least 4).
REQ-003 SHALL have parameter GPRS_WIDTH, default $clog2(GPRS_NUM), register index width.
REQ-004 SHALL have parameter RD_PORTS, default 3, number of read ports.
REQ-005 SHALL have parameter WR_PORTS, default 2, number of write ports.
REQ-006 SHALL have port i_clk, input, 1, the single clock; all state on rising edge.
REQ-007 SHALL have port i_rst_n, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have port i_clr, input, 1, request a full register clear sweep.
REQ-009 SHALL have port o_ready, output, 1, high when not sweeping.
REQ-010 SHALL have port i_rd_id, input, RD_PORTS*GPRS_WIDTH, packed read indices; port k at bits [k*GPRS_WIDTH +: GPRS_WIDTH].
REQ-011 SHALL have port o_rd_data, output, RD_PORTS*DATA_WIDTH, packed read data, same packing.
REQ-012 SHALL have port o_rd_busy, output, RD_PORTS, scoreboard busy bit of each read index.
REQ-013 SHALL have port i_wr_en, input, WR_PORTS, per-port write enable.
REQ-014 SHALL have port i_wr_id, input, WR_PORTS*GPRS_WIDTH, packed write indices.
REQ-015 SHALL have port i_wr_data, input, WR_PORTS*DATA_WIDTH, packed write data.
REQ-016 SHALL have port i_iss_en, input, 1, mark destination register busy.
REQ-017 SHALL have port i_iss_id, input, GPRS_WIDTH, index marked busy.

Function
REQ-018 Register 0 SHALL always read 0, never be written, and never read busy.
REQ-019 Reads SHALL be combinational (zero latency) from storage.
REQ-020 Write-through bypass: if an enabled write in the same cycle targets a nonzero read index, o_rd_data SHALL return that write data.
REQ-021 Several enabled write ports on one index: the highest-numbered port SHALL win, both in storage and in the bypass.
REQ-022 Writes SHALL update storage on the rising edge; a write to index 0 SHALL be ignored.
REQ-023 Scoreboard: one busy bit per register. i_iss_en sets busy[i_iss_id] at the next edge. Any enabled write clears busy[i_wr_id] at the next edge.
REQ-024 Issue and write to the same index in one cycle: busy SHALL end set, because issue wins.
REQ-025 o_rd_busy SHALL show registered busy state with no bypass; a same-cycle issue becomes visible one cycle later.
REQ-026 FSM states are IDLE and CLEAR. In IDLE, i_clr=1 moves to CLEAR at the next edge with sweep counter = 1.
REQ-027 In CLEAR, each cycle writes 0 to register[counter] and increments the counter. Leaving CLEAR, the FSM returns to IDLE after the edge that clears register GPRS_NUM-1, i.e. GPRS_NUM-1 cycles in CLEAR.
REQ-028 In CLEAR, o_ready SHALL be 0, all writes and issues are ignored, o_rd_data reads 0 and o_rd_busy reads 0 on every port.
REQ-029 i_clr asserted during CLEAR SHALL be ignored (no restart). i_clr held high at the exit of CLEAR SHALL start a new sweep only after one IDLE cycle.
REQ-030 All busy bits SHALL clear on entry to CLEAR.

Reset
REQ-031 Asserting i_rst_n=0 SHALL immediately and asynchronously: set FSM to CLEAR, counter to 1, clear all busy bits, drive o_ready=0.
REQ-032 Storage SHALL have no reset; after reset deassertion the sweep zeroes it, and o_ready rises GPRS_NUM-1 cycles after the first active edge.
REQ-033 Reset asserted mid-sweep SHALL restart the sweep from counter 1.

Verification
REQ-034 Reset then wait: o_ready=0 for 31 cycles, then 1. All ports read 0 with busy=0.
REQ-035 Write port0 id 5 = 0xDEADBEEF while reading id 5 in the same cycle -> o_rd_data=0xDEADBEEF that cycle and every later cycle.
REQ-036 Same-cycle writes: port0 id 7 = 0x11, port1 id 7 = 0x22 -> reads 0x22; write to id 0 = 0xFF -> reads 0.
REQ-037 Issue id 9 -> busy at cycle+1. Write id 9 -> busy clear at cycle+1. Issue and write id 9 together -> busy stays 1.
REQ-038 i_clr with registers holding data -> o_ready=0 for 31 cycles, reads 0 throughout. i_clr pulsed again mid-sweep -> duration unchanged. Afterwards all registers read 0.
REQ-039 Assert i_rst_n=0 at sweep cycle 10 -> o_ready stays 0 for a full 31 cycles after release.
